// File: rtl/aes_round_ctrl_pkg.sv
// aes_round_ctrl_pkg: shared state encoding, AES-128 round constants and the xtime helper
package aes_round_ctrl_pkg;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_WAIT, S_DONE} state_t;

   localparam int         AES_NR    = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1B;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_round_ctrl_rcon.sv
// aes_round_ctrl_rcon: round-constant register, reloaded on init and doubled in GF(2^8) on advance
module aes_round_ctrl_rcon
   import aes_round_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       init_i,
   input  logic       adv_i,
   output logic [7:0] rcon_o
);

   logic [7:0] rcon_q, rcon_d;

   // init has priority so a fresh encryption always starts from 01
   always_comb rcon_d = init_i ? RCON_INIT : adv_i ? xtime(rcon_q) : rcon_q;

   // constant register
   always_ff @(posedge clk or posedge rst)
      if (rst) rcon_q <= RCON_INIT;
      else     rcon_q <= rcon_d;

   assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences load/round handshakes with the AES-128 datapath and captures the ciphertext
module aes_round_ctrl
   import aes_round_ctrl_pkg::*;
#(
   parameter int NR      = AES_NR,
   parameter int TIMEOUT = 255
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         engine_start,
   input  logic [127:0] plain_in,
   input  logic [127:0] key_in,
   output logic         engine_done,
   output logic [127:0] dp_plain,
   output logic [127:0] dp_key,
   output logic         dp_load,
   output logic         dp_round_en,
   output logic         dp_final,
   output logic [3:0]   round_idx,
   output logic [7:0]   rcon,
   input  logic         dp_round_ack,
   input  logic [127:0] dp_state,
   output logic [127:0] cipher_out,
   output logic         cipher_valid,
   output logic         err
);

   localparam int             WDW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] TO_L = WDW'(TIMEOUT);
   localparam logic [3:0]     NR_L = 4'(NR);

   state_t         state_q, state_d;
   logic [3:0]     round_q, round_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [127:0]   plain_q, plain_d, key_q, key_d, cipher_q, cipher_d;
   logic           err_q, err_d;
   logic           rc_init, rc_adv;

   // next-state and register updates; a zero TIMEOUT never trips the watchdog
   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      wd_d     = wd_q;
      plain_d  = plain_q;
      key_d    = key_q;
      cipher_d = cipher_q;
      err_d    = err_q;
      rc_init  = 1'b0;
      rc_adv   = 1'b0;
      case (state_q)
         S_IDLE:
            if (engine_start) begin
               plain_d = plain_in;
               key_d   = key_in;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         S_LOAD: begin
            round_d = 4'd1;
            rc_init = 1'b1;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT:
            if (dp_round_ack) begin
               if (round_q == NR_L) begin
                  cipher_d = dp_state;
                  state_d  = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
                  rc_adv  = 1'b1;
                  state_d = S_ROUND;
               end
            end else if (TIMEOUT != 0 && wd_q == TO_L) begin
               err_d   = 1'b1;
               round_d = 4'd0;
               state_d = S_IDLE;
            end else wd_d = wd_q + 1'b1;
         S_DONE: begin
            round_d = 4'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath-facing registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= S_IDLE;
         round_q  <= 4'd0;
         wd_q     <= '0;
         plain_q  <= '0;
         key_q    <= '0;
         cipher_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         wd_q     <= wd_d;
         plain_q  <= plain_d;
         key_q    <= key_d;
         cipher_q <= cipher_d;
         err_q    <= err_d;
      end

   aes_round_ctrl_rcon u_rcon (
      .clk   (clk),
      .rst   (rst),
      .init_i(rc_init),
      .adv_i (rc_adv),
      .rcon_o(rcon)
   );

   assign engine_done  = state_q == S_IDLE;
   assign dp_load      = state_q == S_LOAD;
   assign dp_round_en  = state_q == S_ROUND;
   assign dp_final     = state_q == S_ROUND && round_q == NR_L;
   assign cipher_valid = state_q == S_DONE;
   assign round_idx    = round_q;
   assign dp_plain     = plain_q;
   assign dp_key       = key_q;
   assign cipher_out   = cipher_q;
   assign err          = err_q;

endmodule
